// File: rtl/seq_detect_param_if.sv
// Bus bundle for seq_detect_param: serial data, configuration strobe and
// the detector's result signals. The master drives data/config and reads
// results; the slave is the detector itself.
interface seq_detect_param_if #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
) ();
  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               z;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;

  modport master (
    output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    input  z, match_cnt, cfg_err
  );

  modport slave (
    input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
    output z, match_cnt, cfg_err
  );
endinterface

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector. A history shift register
// holds the most recent MAX_LEN valid bits; a fill counter tracks how many
// of them belong to the current search window. The low cfg_len bits of the
// shifted history are compared against the shadowed pattern each valid bit.
// A match produces a one-cycle registered pulse on z and bumps a saturating
// match counter. Non-overlapping mode restarts the window after each match.
module seq_detect_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
) (
  input logic               clk,
  input logic               reset,
  seq_detect_param_if.slave bus
);

  localparam int                 FILL_W  = $clog2(MAX_LEN + 1);
  localparam logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(32'h1B);
  localparam logic [LEN_W-1:0]   DEF_LEN = LEN_W'(5);
  localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(MAX_LEN);

  // Active configuration (shadow registers)
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;

  // Detection state
  logic [MAX_LEN-1:0] hist_q;
  logic [FILL_W-1:0]  fill_q;
  logic               z_p1;
  logic [CNT_W-1:0]   cnt_q;

  // Combinational compare
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic               len_bad;
  logic               enough;
  logic               hit_p0;

  // Length legality, next history, length mask and the match decision
  always_comb begin
    len_bad  = (32'(len_q) < 32'd2) || (32'(len_q) > 32'(MAX_LEN));
    hist_nxt = {hist_q[MAX_LEN-2:0], bus.din};
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (32'(i) < 32'(len_q));
    end
    enough = (32'(fill_q) + 32'd1) >= 32'(len_q);
    hit_p0 = bus.din_valid && !len_bad && enough &&
             (((hist_nxt ^ pat_q) & mask) == '0);
  end

  // Shadow configuration: defaults on reset, captured on cfg_load
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q <= DEF_PAT;
      len_q <= DEF_LEN;
      ovl_q <= 1'b1;
    end else if (bus.cfg_load) begin
      pat_q <= bus.cfg_pattern;
      len_q <= bus.cfg_len;
      ovl_q <= bus.cfg_overlap;
    end
  end

  // ---- stage p0 -> p1: history, fill, match pulse and counter ----
  // A cfg_load clears the search state and discards a same-cycle valid bit.
  always_ff @(posedge clk) begin
    if (reset || bus.cfg_load) begin
      hist_q <= '0;
      fill_q <= '0;
      z_p1   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      z_p1 <= hit_p0;
      if (bus.din_valid) begin
        hist_q <= hist_nxt;
        if (hit_p0 && !ovl_q) begin
          fill_q <= '0;
        end else if (fill_q != FILL_MAX) begin
          fill_q <= fill_q + FILL_W'(1);
        end
      end
      if (hit_p0 && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.z         = z_p1;
  assign bus.match_cnt = cnt_q;
  assign bus.cfg_err   = len_bad;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (8-bit and 2-bit match counter)
// share one stimulus stream. A queue-based model of the detection rules is
// compared with both instances every cycle, and directed scenarios pin the
// model with hand-computed expectations.
module tb_seq_detect_param;

  localparam int ML = 8;

  logic clk;
  logic reset;

  seq_detect_param_if #(.MAX_LEN(ML), .CNT_W(8), .LEN_W(4)) ifa ();
  seq_detect_param_if #(.MAX_LEN(ML), .CNT_W(2), .LEN_W(4)) ifb ();

  assign ifb.din_valid   = ifa.din_valid;
  assign ifb.din         = ifa.din;
  assign ifb.cfg_load    = ifa.cfg_load;
  assign ifb.cfg_pattern = ifa.cfg_pattern;
  assign ifb.cfg_len     = ifa.cfg_len;
  assign ifb.cfg_overlap = ifa.cfg_overlap;

  seq_detect_param #(.MAX_LEN(ML), .CNT_W(8), .LEN_W(4)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  seq_detect_param #(.MAX_LEN(ML), .CNT_W(2), .LEN_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Reference model: the bits seen since the window last restarted
  logic [ML-1:0] m_pat;
  int            m_len;
  bit            m_ovl;
  bit            m_z;
  int            m_cnt;
  bit            q[$];

  function automatic bit m_legal();
    return (m_len >= 2) && (m_len <= ML);
  endfunction

  function automatic bit tail_match();
    if (q.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_pat = ML'(8'h1B); m_len = 5; m_ovl = 1'b1;
        q.delete(); m_z = 1'b0; m_cnt = 0;
      end else if (ifa.cfg_load) begin
        m_pat = ifa.cfg_pattern; m_len = int'(ifa.cfg_len); m_ovl = ifa.cfg_overlap;
        q.delete(); m_z = 1'b0; m_cnt = 0;
      end else begin
        m_z = 1'b0;
        if (ifa.din_valid) begin
          q.push_back(ifa.din);
          if (q.size() > ML) void'(q.pop_front());
          if (m_legal() && tail_match()) begin
            m_z = 1'b1;
            m_cnt++;
            if (!m_ovl) q.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("z_a", 32'(ifa.z), 32'(m_z));
        check("z_b", 32'(ifb.z), 32'(m_z));
        check("cnt_a", 32'(ifa.match_cnt), 32'(sat(m_cnt, 255)));
        check("cnt_b", 32'(ifb.match_cnt), 32'(sat(m_cnt, 3)));
        check("cfg_err", 32'(ifa.cfg_err), 32'(!m_legal()));
      end
    end
  end

  task automatic step(input bit v, input bit d);
    ifa.din_valid = v;
    ifa.din       = d;
    @(posedge clk); #1;
    ifa.din_valid = 1'b0;
  endtask

  task automatic load(input logic [ML-1:0] p, input int len, input bit ovl, input bit v, input bit d);
    ifa.cfg_load    = 1'b1;
    ifa.cfg_pattern = p;
    ifa.cfg_len     = 4'(len);
    ifa.cfg_overlap = ovl;
    ifa.din_valid   = v;
    ifa.din         = d;
    @(posedge clk); #1;
    ifa.cfg_load  = 1'b0;
    ifa.din_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ifa.din_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  bit s1[8] = '{1, 1, 0, 1, 1, 0, 1, 1};
  bit e1[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
  bit e2[8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  bit s3[5] = '{1, 1, 0, 1, 1};
  bit e3[5] = '{0, 0, 0, 0, 1};

  initial begin
    reset = 1'b1;
    ifa.din_valid = 1'b0; ifa.din = 1'b0; ifa.cfg_load = 1'b0;
    ifa.cfg_pattern = '0; ifa.cfg_len = '0; ifa.cfg_overlap = 1'b0;
    do_reset(2);
    chk_on = 1'b1;

    check("rst_z", 32'(ifa.z), 32'd0);
    check("rst_cnt", 32'(ifa.match_cnt), 32'd0);
    check("rst_err", 32'(ifa.cfg_err), 32'd0);

    // Default overlapping pattern 11011 on 11011011
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s1[i]);
      check($sformatf("ovl_z%0d", i + 1), 32'(ifa.z), 32'(e1[i]));
    end
    check("ovl_cnt", 32'(ifa.match_cnt), 32'd2);

    // Non-overlapping: same stream, then 11011 appended
    load(ML'(8'h1B), 5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s1[i]);
      check($sformatf("novl_z%0d", i + 1), 32'(ifa.z), 32'(e2[i]));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, s3[i]);
      check($sformatf("novl_tail_z%0d", i + 1), 32'(ifa.z), 32'(e3[i]));
    end
    check("novl_cnt", 32'(ifa.match_cnt), 32'd2);

    // Valid gaps between bits
    load(ML'(8'h1B), 5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, s3[i]);
      repeat (3) step(1'b0, 1'b1);
    end
    step(1'b1, 1'b1);
    check("gap_z4", 32'(ifa.z), 32'd0);
    step(1'b1, 1'b1);
    check("gap_z5", 32'(ifa.z), 32'd1);
    step(1'b0, 1'b1);
    check("gap_idle_z", 32'(ifa.z), 32'd0);
    check("gap_cnt", 32'(ifa.match_cnt), 32'd1);

    // Illegal lengths
    load(ML'(8'h03), 0, 1'b1, 1'b0, 1'b0);
    check("len0_err", 32'(ifa.cfg_err), 32'd1);
    repeat (12) step(1'b1, 1'($urandom));
    check("len0_cnt", 32'(ifa.match_cnt), 32'd0);
    load(ML'(8'hFF), ML + 1, 1'b1, 1'b0, 1'b0);
    check("len9_err", 32'(ifa.cfg_err), 32'd1);
    repeat (12) step(1'b1, 1'b1);
    check("len9_cnt", 32'(ifa.match_cnt), 32'd0);

    // Full-length all-ones pattern
    load(ML'(8'hFF), ML, 1'b1, 1'b0, 1'b0);
    check("lenmax_err", 32'(ifa.cfg_err), 32'd0);
    for (int i = 1; i <= ML; i++) begin
      step(1'b1, 1'b1);
      check($sformatf("ones_z%0d", i), 32'(ifa.z), 32'(i == ML));
    end

    // Back-to-back loads apply the last; same-cycle valid bit is dropped
    load(ML'(8'h05), 3, 1'b1, 1'b0, 1'b0);
    load(ML'(8'h03), 2, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("b2b_z1", 32'(ifa.z), 32'd0);
    step(1'b1, 1'b1);
    check("b2b_z2", 32'(ifa.z), 32'd1);

    // Reset mid-sequence discards the partial match
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, s1[i]);
    do_reset(1);
    step(1'b1, 1'b1);
    check("midrst_z", 32'(ifa.z), 32'd0);
    check("midrst_cnt", 32'(ifa.match_cnt), 32'd0);

    // Five matches: narrow counter saturates at 3
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1'b1, s3[i]);
    repeat (4) begin
      step(1'b1, 1'b0); step(1'b1, 1'b1); step(1'b1, 1'b1);
    end
    check("sat_cnt_b", 32'(ifb.match_cnt), 32'd3);
    check("sat_cnt_a", 32'(ifa.match_cnt), 32'd5);

    // Randomized traffic, configs and resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        do_reset(1);
      end else if (r < 8) begin
        load(ML'($urandom), int'($urandom_range(0, ML + 1)), 1'($urandom),
             1'($urandom), 1'($urandom));
      end else begin
        step(($urandom_range(0, 3) != 0), 1'($urandom));
      end
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, meaning maximum pattern length in bits (legal range 2..32).
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the match counter.
REQ-003 SHALL have parameter LEN_W, default 4, meaning width of cfg_len; LEN_W SHALL be at least clog2(MAX_LEN+1).
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port din_valid  input  1  qualifies din; a bit is consumed only when this is high.
REQ-007 SHALL have port din  input  1  serial data bit.
REQ-008 SHALL have port cfg_load  input  1  one-cycle strobe that captures cfg_pattern, cfg_len and cfg_overlap.
REQ-009 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit [cfg_len-1] is the first bit received and bit [0] is the last.
REQ-010 SHALL have port cfg_len  input  LEN_W  pattern length in bits.
REQ-011 SHALL have port cfg_overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
REQ-012 SHALL have port z  output  1  registered one-cycle match pulse.
REQ-013 SHALL have port match_cnt  output  CNT_W  saturating count of matches.
REQ-014 SHALL have port cfg_err  output  1  high while the active configuration is illegal.

Function
REQ-015 SHALL hold the active configuration in shadow registers, which change only on cfg_load.
REQ-016 SHALL keep a MAX_LEN-bit history register; on each valid bit, hist <= {hist[MAX_LEN-2:0], din}.
REQ-017 SHALL keep a fill counter (0..MAX_LEN) that increments per valid bit and saturates at MAX_LEN.
REQ-018 SHALL declare a match on a valid bit when all of these hold:
  - (fill+1) >= len
  - the next hist[len-1:0] equals pattern[len-1:0]
  - cfg_err is low
REQ-019 SHALL assert z for exactly one cycle, in the cycle after the clock edge that consumed the completing bit (latency 1).
REQ-020 SHALL deassert z in any cycle that follows a clock edge with din_valid low.
REQ-021 SHALL, in overlap mode, continue shifting after a match so that suffix bits count toward the next match.
REQ-022 SHALL, in non-overlap mode, set fill to 0 on a match so that the next match needs len fresh bits.
REQ-023 SHALL increment match_cnt by 1 per match and saturate at all-ones without wrapping.
REQ-024 SHALL treat cfg_len < 2 or cfg_len > MAX_LEN as illegal: cfg_err = 1, no matches, match_cnt frozen.
REQ-025 SHALL, on cfg_load, load the shadows and clear hist, fill, z and match_cnt in that cycle; a din_valid in the same cycle SHALL be discarded.
REQ-026 SHALL, on back-to-back cfg_load strobes, apply the last one.
REQ-027 SHALL ignore pattern bits above cfg_len-1 in the comparison.

Reset
REQ-028 SHALL, on reset, clear hist, fill, z and match_cnt.
REQ-029 SHALL, on reset, load the defaults pattern = 5'b11011 (zero-extended), len = 5 and overlap = 1, giving cfg_err = 0.
REQ-030 SHALL give reset priority over cfg_load and din_valid; a reset mid-sequence SHALL discard the partial match.

Verification
REQ-031 SHALL cover: after reset, din_valid = 1 with stream 1,1,0,1,1,0,1,1 -> z pulses after bits 5 and 8, match_cnt = 2.
REQ-032 SHALL cover: cfg_load with overlap = 0, then the same stream 11011011 -> z after bit 5 only; bits 1,1,0,1,1 appended -> second z, match_cnt = 2.
REQ-033 SHALL cover: stream 1,1,0 with valid gaps of 3 idle cycles between bits, then 1,1 -> a single z, one cycle after the fifth valid bit.
REQ-034 SHALL cover: cfg_len = 0 and cfg_len = MAX_LEN+1 -> cfg_err = 1, z stays 0 for any stream; cfg_len = MAX_LEN with an all-ones pattern -> z after the MAX_LEN-th consecutive 1.
REQ-035 SHALL cover: reset asserted after bits 1,1,0,1, then bit 1 -> no z; match_cnt = 0.
REQ-036 SHALL cover: CNT_W = 2 with 5 matches -> match_cnt holds 3.
